// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, instruction field offsets and class codes for seq_control_unit.
package ctrl_pkg;
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;
    localparam int CLASS_LSB = 1;
    localparam int CARRY_BIT = 2;
    localparam int OP_MSB    = 3;
    localparam int JSEL_MSB  = 9;
    localparam int JCTRL_MSB = 12;
    localparam logic [1:0] NORMAL = 2'b00;
    localparam logic [1:0] SYS    = 2'b11;
    typedef struct packed {
        logic       stk_addr_sel;
        logic       stk_w;
        logic       stk_s;
        logic [2:0] sp;
        logic       r_w;
        logic       r_s;
        logic       carry_w;
        logic       instr_type;
    } flags_t;
endpackage

// File: rtl/ctrl_field_decode.sv
// ctrl_field_decode: combinational IR-to-controls mapping plus halt/illegal class flags.
module ctrl_field_decode
    import ctrl_pkg::*;
#(
    parameter int JCTRL_W = 6,
    parameter int OP_W    = 5,
    parameter int JSEL_W  = 3,
    localparam int INSTR_W = 12 + JCTRL_W
) (
    input  logic [INSTR_W-1:0] ir_i,
    output flags_t             flags_o,
    output logic [OP_W-1:0]    op_o,
    output logic [JSEL_W-1:0]  jsel_o,
    output logic [JCTRL_W-1:0] jctrl_o,
    output logic               halt_o,
    output logic               illegal_o
);
    // Ascending view so indices match the instruction's bit-0-is-MSB numbering.
    logic [0:INSTR_W-1] b;
    logic [1:0]         cls;
    logic [OP_W-1:0]    op;
    logic               normal;
    logic               unused_rsvd;
    assign b           = ir_i;
    assign cls         = b[0:CLASS_LSB];
    assign op          = b[OP_MSB +: OP_W];
    assign normal      = cls == NORMAL;
    assign halt_o      = cls == SYS && &op;
    assign illegal_o   = !normal && !halt_o;
    assign unused_rsvd = b[8];
    always_comb begin
        flags_o              = '0;
        flags_o.stk_addr_sel = normal & ~b[OP_MSB] & b[OP_MSB+1];
        flags_o.stk_w        = normal & b[OP_MSB] & b[OP_MSB+4];
        flags_o.stk_s        = normal & b[OP_MSB];
        flags_o.sp           = {flags_o.stk_addr_sel, 2'b00};
        flags_o.r_w          = normal & b[OP_MSB+3];
        flags_o.r_s          = normal & ~b[OP_MSB] & ~b[OP_MSB+1];
        flags_o.carry_w      = normal & b[CARRY_BIT];
        flags_o.instr_type   = normal & b[CARRY_BIT];
        op_o                 = normal ? op : '0;
        jsel_o               = normal ? b[JSEL_MSB +: JSEL_W] : '0;
        jctrl_o              = normal ? b[JCTRL_MSB +: JCTRL_W] : '0;
    end
endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: registered multi-cycle instruction decoder with stall, trap, halt and retire counter.
module seq_control_unit
    import ctrl_pkg::*;
#(
    parameter int JCTRL_W     = 6,
    parameter int OP_W        = 5,
    parameter int JSEL_W      = 3,
    parameter int STK_WB_2CYC = 1,
    parameter int CNT_W       = 16,
    localparam int INSTR_W    = 12 + JCTRL_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic               i_stall,
    output logic               o_ctrl_valid,
    output logic               o_wb_phase,
    output logic               o_stkAddrSel,
    output logic               o_stkWCtrl,
    output logic               o_stkSCtrl,
    output logic               o_RWCtrl,
    output logic               o_RSCtrl,
    output logic               o_carryWCtrl,
    output logic               o_instrTypeCtrl,
    output logic [2:0]         o_spCtrl,
    output logic [OP_W-1:0]    o_instrOP,
    output logic [JSEL_W-1:0]  o_jSelCtrl,
    output logic [JCTRL_W-1:0] o_jCtrl,
    output logic               o_illegal,
    output logic               o_halted,
    output logic [CNT_W-1:0]   o_retired
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    flags_t             flags_q, flags_d, dec_flags;
    logic [OP_W-1:0]    op_q, op_d, dec_op;
    logic [JSEL_W-1:0]  jsel_q, jsel_d, dec_jsel;
    logic [JCTRL_W-1:0] jctrl_q, jctrl_d, dec_jctrl;
    logic               illegal_q, illegal_d, dec_halt, dec_illegal;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;

    ctrl_field_decode #(.JCTRL_W(JCTRL_W), .OP_W(OP_W), .JSEL_W(JSEL_W)) u_dec (
        .ir_i     (ir_q),
        .flags_o  (dec_flags),
        .op_o     (dec_op),
        .jsel_o   (dec_jsel),
        .jctrl_o  (dec_jctrl),
        .halt_o   (dec_halt),
        .illegal_o(dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        op_d      = op_q;
        jsel_d    = jsel_q;
        jctrl_d   = jctrl_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            IDLE: if (i_instr_valid) begin
                ir_d    = i_instr;
                state_d = DECODE;
            end
            DECODE: begin
                // Decoder zeroes every field for non-normal classes, so trap/halt leave controls at 0.
                flags_d   = dec_flags;
                op_d      = dec_op;
                jsel_d    = dec_jsel;
                jctrl_d   = dec_jctrl;
                illegal_d = dec_illegal;
                state_d   = dec_halt ? HALT : dec_illegal ? IDLE : EXEC;
            end
            EXEC, WB: if (!i_stall) begin
                if (state_q == EXEC && flags_q.stk_w && STK_WB_2CYC != 0) begin
                    state_d = WB;
                end else begin
                    retire  = 1'b1;
                    flags_d = '0;
                    op_d    = '0;
                    jsel_d  = '0;
                    jctrl_d = '0;
                    state_d = IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            flags_q   <= '0;
            op_q      <= '0;
            jsel_q    <= '0;
            jctrl_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            op_q      <= op_d;
            jsel_q    <= jsel_d;
            jctrl_q   <= jctrl_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign o_instr_ready   = state_q == IDLE;
    assign o_ctrl_valid    = state_q == EXEC || state_q == WB;
    assign o_wb_phase      = state_q == WB;
    assign o_halted        = state_q == HALT;
    assign o_illegal       = illegal_q;
    assign o_retired       = retired_q;
    assign o_stkAddrSel    = flags_q.stk_addr_sel;
    assign o_stkWCtrl      = flags_q.stk_w;
    assign o_stkSCtrl      = flags_q.stk_s;
    assign o_spCtrl        = flags_q.sp;
    assign o_RWCtrl        = flags_q.r_w;
    assign o_RSCtrl        = flags_q.r_s;
    assign o_carryWCtrl    = flags_q.carry_w;
    assign o_instrTypeCtrl = flags_q.instr_type;
    assign o_instrOP       = op_q;
    assign o_jSelCtrl      = jsel_q;
    assign o_jCtrl         = jctrl_q;
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: directed checks of decode, stall, trap, halt, wrap and async reset.
module tb_seq_control_unit;
    logic        clk, rst, valid, stall;
    logic [17:0] instr;
    logic        ready, cv, wb, sas, sw, ss, rw, rs, cw, it, ill, hlt;
    logic [2:0]  sp;
    logic [4:0]  op;
    logic [2:0]  js;
    logic [5:0]  jc;
    logic [15:0] ret;
    logic        ready2, cv2, wb2, sas2, sw2, ss2, rw2, rs2, cw2, it2, ill2, hlt2;
    logic [2:0]  sp2;
    logic [4:0]  op2;
    logic [2:0]  js2;
    logic [5:0]  jc2;
    logic [3:0]  ret2;
    int          checks, failures;
    logic        saw_wb2;

    localparam logic [17:0] I_STK  = {2'b00, 1'b1, 5'b10011, 1'b0, 3'b101, 6'b000011};
    localparam logic [17:0] I_PLN  = {2'b00, 1'b0, 5'b01000, 1'b0, 3'b010, 6'b100001};
    localparam logic [17:0] I_ILL  = {2'b01, 1'b1, 5'b10011, 1'b0, 3'b101, 6'b000011};
    localparam logic [17:0] I_HALT = {2'b11, 1'b0, 5'b11111, 1'b0, 3'b000, 6'b000000};

    seq_control_unit dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(valid), .o_instr_ready(ready),
        .i_stall(stall), .o_ctrl_valid(cv), .o_wb_phase(wb), .o_stkAddrSel(sas), .o_stkWCtrl(sw),
        .o_stkSCtrl(ss), .o_RWCtrl(rw), .o_RSCtrl(rs), .o_carryWCtrl(cw), .o_instrTypeCtrl(it),
        .o_spCtrl(sp), .o_instrOP(op), .o_jSelCtrl(js), .o_jCtrl(jc), .o_illegal(ill),
        .o_halted(hlt), .o_retired(ret)
    );

    seq_control_unit #(.STK_WB_2CYC(0), .CNT_W(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(valid), .o_instr_ready(ready2),
        .i_stall(stall), .o_ctrl_valid(cv2), .o_wb_phase(wb2), .o_stkAddrSel(sas2), .o_stkWCtrl(sw2),
        .o_stkSCtrl(ss2), .o_RWCtrl(rw2), .o_RSCtrl(rs2), .o_carryWCtrl(cw2), .o_instrTypeCtrl(it2),
        .o_spCtrl(sp2), .o_instrOP(op2), .o_jSelCtrl(js2), .o_jCtrl(jc2), .o_illegal(ill2),
        .o_halted(hlt2), .o_retired(ret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        saw_wb2 = saw_wb2 | wb2;
    endtask

    initial begin
        checks = 0; failures = 0; saw_wb2 = 1'b0;
        rst = 1'b1; valid = 1'b0; stall = 1'b0; instr = '0;
        #1;
        chk("rst_ready", {31'b0, ready}, 1);
        chk("rst_cv", {31'b0, cv}, 0);
        chk("rst_halted", {31'b0, hlt}, 0);
        chk("rst_illegal", {31'b0, ill}, 0);
        chk("rst_retired", {16'b0, ret}, 0);
        chk("rst_op", {27'b0, op}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic decode of a stack-writing instruction
        instr = I_STK; valid = 1'b1;
        chk("basic_ready_idle", {31'b0, ready}, 1);
        tick();
        valid = 1'b0;
        chk("basic_ready_dec", {31'b0, ready}, 0);
        chk("basic_cv_dec", {31'b0, cv}, 0);
        tick();
        chk("basic_cv_exec", {31'b0, cv}, 1);
        chk("basic_wb_exec", {31'b0, wb}, 0);
        chk("basic_flags", {25'b0, sas, sw, ss, rw, rs, cw, it}, 32'b0111011);
        chk("basic_sp", {29'b0, sp}, 0);
        chk("basic_op", {27'b0, op}, 5'b10011);
        chk("basic_jsel", {29'b0, js}, 3'b101);
        chk("basic_jctrl", {26'b0, jc}, 6'b000011);
        chk("basic2_cv_exec", {31'b0, cv2}, 1);
        tick();
        chk("basic_wb", {31'b0, wb}, 1);
        chk("basic_cv_wb", {31'b0, cv}, 1);
        chk("basic_ret_wb", {16'b0, ret}, 0);
        chk("basic2_nowb", {30'b0, wb2, cv2}, 0);
        chk("basic2_ret", {28'b0, ret2}, 1);
        tick();
        chk("basic_ret", {16'b0, ret}, 1);
        chk("basic_cv_idle", {31'b0, cv}, 0);
        chk("basic_op_clr", {27'b0, op}, 0);
        chk("basic_ready_back", {31'b0, ready}, 1);

        // Stall holds EXEC for four cycles in total
        instr = I_STK; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_exec", {24'b0, cv, wb, sw, op}, {24'b0, 1'b1, 1'b0, 1'b1, 5'b10011});
        end
        stall = 1'b0;
        tick();
        chk("stall_wb", {31'b0, wb}, 1);
        chk("stall_ret_wb", {16'b0, ret}, 1);
        tick();
        chk("stall_ret", {16'b0, ret}, 2);
        chk("stall_idle", {30'b0, ready, cv}, 2'b10);

        // Illegal class traps without retiring
        instr = I_ILL; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("ill_dec", {30'b0, ill, ready}, 0);
        tick();
        chk("ill_pulse", {31'b0, ill}, 1);
        chk("ill_cv", {31'b0, cv}, 0);
        chk("ill_ready", {31'b0, ready}, 1);
        chk("ill_op", {27'b0, op}, 0);
        tick();
        chk("ill_pulse_end", {31'b0, ill}, 0);
        chk("ill_ret", {16'b0, ret}, 2);

        // Async reset while in EXEC
        instr = I_STK; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("ar_cv_before", {31'b0, cv}, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cv", {31'b0, cv}, 0);
        chk("ar_ctrl", {26'b0, sw, ss, rw, cw, it, wb}, 0);
        chk("ar_op", {21'b0, op, js, jc[2:0]}, 0);
        chk("ar_ret", {16'b0, ret}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Non-stack instruction, 16 retirements; 4-bit counter wraps
        saw_wb2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            instr = I_PLN; valid = 1'b1;
            tick();
            valid = 1'b0;
            tick();
            if (i == 0) begin
                chk("pln_flags", {25'b0, sas2, sw2, ss2, rw2, rs2, cw2, it2}, 32'b1000000);
                chk("pln_sp", {29'b0, sp2}, 3'b100);
                chk("pln_fields", {18'b0, op2, js2, jc2}, {18'b0, 5'b01000, 3'b010, 6'b100001});
            end
            tick();
            if (i == 14) chk("wrap_15", {28'b0, ret2}, 15);
        end
        chk("wrap_0", {28'b0, ret2}, 0);
        chk("wrap_ret16", {16'b0, ret}, 16);
        chk("wrap_nowb", {31'b0, saw_wb2}, 0);

        // Halt is absorbing until reset
        instr = I_HALT; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("halt_flag", {31'b0, hlt}, 1);
        chk("halt_ready", {30'b0, ready, cv}, 0);
        instr = I_STK; valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold", {29'b0, hlt, ready, cv}, 3'b100);
        end
        chk("halt_ret", {16'b0, ret}, 16);
        valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst", {30'b0, hlt, ready}, 2'b01);
        tick();
        rst = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
